// File: rtl/pattern_player.sv
// ---------------------------------------------------------------------------
// pattern_player
//
// Pattern sequencer. A DATA_WIDTH x 2^ADDR_WIDTH table, written by a host
// port, is played out by an internal address counter at a programmable step
// rate. Three playback modes: wrap, one-shot and ping-pong.
//
// Output handshake: o_valid is a one-cycle strobe that marks a fresh sample
// on o_data/o_addr. There is no back-pressure. Consumers must take the
// sample in the cycle o_valid is high. o_data and o_addr hold their value
// between strobes.
//
// Parameters
//   ADDR_WIDTH  table address width (depth = 2^ADDR_WIDTH)
//   DATA_WIDTH  table word width
//   DIV_WIDTH   step divider width (one step every D+1 cycles)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_wr_en      table write strobe (honoured in any state)
//   i_wr_addr    table write address
//   i_wr_data    table write data
//   i_start      start / restart playback (level, sampled every edge)
//   i_stop       abort playback (wins over i_start and over a step)
//   i_mode       00 wrap, 01 one-shot, 10 ping-pong, 11 wrap
//   i_last_addr  last address L of the sequence (first address is 0)
//   i_div        step divider D
//   o_data       table word of the current sample
//   o_addr       address the current sample came from
//   o_valid      one-cycle strobe per sample
//   o_busy       high while playing
//   o_done       one-cycle pulse with the final one-shot sample
//   o_state      debug view of the FSM state (0 IDLE, 1 PLAY)
// ---------------------------------------------------------------------------
module pattern_player #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic [1:0]            i_mode,
   input  logic [ADDR_WIDTH-1:0] i_last_addr,
   input  logic [DIV_WIDTH-1:0]  i_div,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_state
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [1:0] MODE_ONESHOT  = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t state;

   // Playback controls, frozen at start so host changes mid-play are ignored.
   logic [1:0]            mode_q;
   logic [ADDR_WIDTH-1:0] last_q;
   logic [DIV_WIDTH-1:0]  div_q;

   logic [ADDR_WIDTH-1:0] addr;
   logic                  dir_down;   // ping-pong direction, 0 = counting up
   logic [DIV_WIDTH-1:0]  divcnt;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Next-address logic, evaluated for the current step.
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  next_dir_down;
   logic                  last_step;
   logic                  step;

   // -------------------------------------------------------------------------
   // Pattern table. Not reset, so its contents survive a reset. A step to
   // the address being written reads the old word, because both the read
   // (o_data <= mem[addr]) and this write are non-blocking updates on the
   // same edge.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign step = (divcnt == div_q);

   // -------------------------------------------------------------------------
   // Address sequencing per mode. The arithmetic is ADDR_WIDTH bits wide,
   // so in wrap mode L = 2^ADDR_WIDTH-1 rolls over to 0 on its own.
   // -------------------------------------------------------------------------
   always_comb begin
      next_addr     = addr + ADDR_ONE;
      next_dir_down = dir_down;
      last_step     = 1'b0;
      case (mode_q)
         MODE_ONESHOT: begin
            last_step = (addr == last_q);
         end
         MODE_PINGPONG: begin
            if (last_q == '0) begin
               // Degenerate ping-pong: one-entry sequence, stay at 0.
               next_addr = '0;
            end else if (!dir_down) begin
               if (addr == last_q) begin
                  // Turn at the top. L is emitted once, then L-1 is next.
                  next_dir_down = 1'b1;
                  next_addr     = addr - ADDR_ONE;
               end
            end else begin
               if (addr == '0) begin
                  // Turn at the bottom. 0 is emitted once, then 1 is next.
                  next_dir_down = 1'b0;
               end else begin
                  next_addr = addr - ADDR_ONE;
               end
            end
         end
         default: begin
            // Wrap. Mode 11 is also treated as wrap.
            if (addr == last_q) begin
               next_addr = '0;
            end
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control FSM with registered outputs.
   // Priority in PLAY: i_stop, then i_start (restart), then the step.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         mode_q   <= 2'b00;
         last_q   <= '0;
         div_q    <= '0;
         addr     <= '0;
         dir_down <= 1'b0;
         divcnt   <= '0;
         o_data   <= '0;
         o_addr   <= '0;
         o_valid  <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         // The strobes are high for one cycle only.
         o_valid <= 1'b0;
         o_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  state    <= PLAY;
                  mode_q   <= i_mode;
                  last_q   <= i_last_addr;
                  div_q    <= i_div;
                  addr     <= '0;
                  dir_down <= 1'b0;
                  divcnt   <= '0;
                  o_busy   <= 1'b1;
               end
            end
            PLAY: begin
               if (i_stop) begin
                  state  <= IDLE;
                  divcnt <= '0;
                  o_busy <= 1'b0;
               end else if (i_start) begin
                  // Restart from address 0 with fresh controls. No sample
                  // is emitted on this edge.
                  mode_q   <= i_mode;
                  last_q   <= i_last_addr;
                  div_q    <= i_div;
                  addr     <= '0;
                  dir_down <= 1'b0;
                  divcnt   <= '0;
               end else if (step) begin
                  o_data   <= mem[addr];
                  o_addr   <= addr;
                  o_valid  <= 1'b1;
                  divcnt   <= '0;
                  addr     <= next_addr;
                  dir_down <= next_dir_down;
                  if (last_step) begin
                     // One-shot end: o_busy drops in the cycle o_done is high.
                     state  <= IDLE;
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                  end
               end else begin
                  divcnt <= divcnt + DIV_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_state = (state == PLAY);

endmodule

// File: tb/tb_pattern_player.sv
// ---------------------------------------------------------------------------
// tb_pattern_player
//
// Self-checking bench for pattern_player. A behavioural model tracks the
// number of cycles since start and derives each sample's address from
// closed-form rules. Emitted samples go through an expected queue.
// ---------------------------------------------------------------------------
module tb_pattern_player;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int VW = 8;

   // ---------------- clock / reset / DUT ----------------
   logic          i_clk;
   logic          i_rst;
   logic          i_wr_en;
   logic [AW-1:0] i_wr_addr;
   logic [DW-1:0] i_wr_data;
   logic          i_start;
   logic          i_stop;
   logic [1:0]    i_mode;
   logic [AW-1:0] i_last_addr;
   logic [VW-1:0] i_div;
   logic [DW-1:0] o_data;
   logic [AW-1:0] o_addr;
   logic          o_valid;
   logic          o_busy;
   logic          o_done;
   logic          o_state;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   pattern_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr_en     (i_wr_en),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .i_start     (i_start),
      .i_stop      (i_stop),
      .i_mode      (i_mode),
      .i_last_addr (i_last_addr),
      .i_div       (i_div),
      .o_data      (o_data),
      .o_addr      (o_addr),
      .o_valid     (o_valid),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_state     (o_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [AW+DW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] m_mem [1 << AW];
   bit            m_play;
   int            m_t;       // edges since the start edge
   int            m_mode;
   int            m_last;
   int            m_div;
   logic          exp_valid;
   logic          exp_done;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;

   // Address of sample number k (0-based) of a sequence.
   function automatic int addr_of(input int mode, input int last, input int k);
      int period;
      int p;
      if (mode == 2) begin
         if (last == 0) return 0;
         period = 2 * last;
         p = k % period;
         return (p <= last) ? p : period - p;
      end
      return k % (last + 1);
   endfunction

   task automatic model_reset();
      m_play    = 1'b0;
      m_t       = 0;
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
   endtask

   task automatic model_latch();
      m_mode = int'(i_mode);
      m_last = int'(i_last_addr);
      m_div  = int'(i_div);
      m_t    = 0;
   endtask

   // Applies the current inputs as one rising edge.
   task automatic model_edge();
      int k;
      int a;
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      if (i_rst) begin
         model_reset();
      end else if (m_play) begin
         if (i_stop) begin
            m_play = 1'b0;
         end else if (i_start) begin
            model_latch();
         end else begin
            m_t++;
            if (m_t % (m_div + 1) == 0) begin
               k = m_t / (m_div + 1) - 1;
               a = addr_of(m_mode, m_last, k);
               exp_addr  = AW'(a);
               exp_data  = m_mem[a];
               exp_valid = 1'b1;
               exp_q.push_back({exp_addr, exp_data});
               if (m_mode == 1 && k == m_last) begin
                  exp_done = 1'b1;
                  m_play   = 1'b0;
               end
            end
         end
      end else if (i_start) begin
         m_play = 1'b1;
         model_latch();
      end
      // The write lands after the read, so a same-edge step sees the old word.
      if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
   endtask

   task automatic check_outputs();
      logic [AW+DW-1:0] s;
      check("valid", 32'(o_valid), 32'(exp_valid));
      check("done",  32'(o_done),  32'(exp_done));
      check("busy",  32'(o_busy),  32'(m_play));
      check("state", 32'(o_state), 32'(m_play));
      check("addr",  32'(o_addr),  32'(exp_addr));
      check("data",  32'(o_data),  32'(exp_data));
      if (o_valid) begin
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check("sample", 32'({o_addr, o_data}), 32'(s));
         end else begin
            check("sample_q_depth", 32'(exp_q.size()), 32'd1);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge i_clk);
      model_edge();
      #1;
      check_outputs();
      @(negedge i_clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asserts reset between edges and checks that the outputs clear at once.
   task automatic async_reset_pulse();
      i_rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      tick();
      i_rst = 1'b0;
   endtask

   task automatic start_play(input logic [1:0] mode, input int last, input int div);
      i_mode      = mode;
      i_last_addr = AW'(last);
      i_div       = VW'(div);
      i_start     = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic stop_play();
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
   endtask

   task automatic write_word(input int a, input logic [DW-1:0] d);
      i_wr_en   = 1'b1;
      i_wr_addr = AW'(a);
      i_wr_data = d;
      tick();
      i_wr_en = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      i_rst = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
      i_start = 1'b0; i_stop = 1'b0; i_mode = 2'b00; i_last_addr = '0; i_div = '0;
      for (int a = 0; a < (1 << AW); a++) m_mem[a] = 'x;
      model_reset();
      @(negedge i_clk);
      async_reset_pulse();
      run(2);

      // Reset: fill the table while reset pulses partway through, then again.
      for (int a = 0; a < (1 << AW); a++) begin
         if (a == 6) async_reset_pulse();
         write_word(a, DW'(a * 16 + 1));
      end
      for (int a = 0; a < (1 << AW); a++) write_word(a, DW'(a * 16 + 1));

      // Wrap, L=3, D=0.
      start_play(2'b00, 3, 0);
      run(10);
      stop_play();
      run(2);

      // One-shot, L=2, D=2.
      start_play(2'b01, 2, 2);
      run(14);

      // Ping-pong, L=3 and L=0.
      start_play(2'b10, 3, 0);
      run(14);
      stop_play();
      start_play(2'b10, 0, 0);
      run(5);
      stop_play();

      // Stop together with start on a step edge (D=1, steps every 2nd edge).
      start_play(2'b00, 3, 1);
      run(3);
      i_stop = 1'b1; i_start = 1'b1;
      tick();
      i_stop = 1'b0; i_start = 1'b0;
      run(3);

      // Restart mid-play.
      start_play(2'b00, 5, 2);
      run(4);
      start_play(2'b00, 5, 2);
      run(8);
      stop_play();

      // Write hazard: write addr 1 on the edge that steps addr 1.
      start_play(2'b00, 3, 0);
      tick();
      i_wr_en = 1'b1; i_wr_addr = AW'(1); i_wr_data = 8'hAA;
      tick();
      i_wr_en = 1'b0;
      run(6);
      stop_play();

      // Full-range wrap, L=15.
      start_play(2'b00, 15, 0);
      run(20);
      stop_play();

      // Reset mid-playback keeps the table.
      start_play(2'b00, 7, 1);
      run(5);
      async_reset_pulse();
      start_play(2'b00, 7, 0);
      run(9);
      stop_play();

      // Randomised segments.
      for (int seg = 0; seg < 40; seg++) begin
         start_play(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 3));
         for (int c = 0, n = $urandom_range(5, 40); c < n; c++) begin
            i_stop  = ($urandom_range(0, 29) == 0);
            i_start = ($urandom_range(0, 24) == 0);
            i_wr_en = ($urandom_range(0, 3) == 0);
            i_wr_addr = AW'($urandom_range(0, 15));
            i_wr_data = DW'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) begin
               i_mode      = 2'($urandom_range(0, 3));
               i_last_addr = AW'($urandom_range(0, 15));
               i_div       = VW'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 199) == 0) begin
               i_stop = 1'b0; i_start = 1'b0; i_wr_en = 1'b0;
               async_reset_pulse();
            end else begin
               tick();
            end
         end
         i_start = 1'b0; i_wr_en = 1'b0;
         stop_play();
      end

      check("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pattern_player.md
# pattern_player

Parametrised pattern sequencer: a writable DATA_WIDTH x 2^ADDR_WIDTH pattern table read out by an internal address counter, with a programmable step rate and three playback modes (wrap, one-shot, ping-pong). It extends the fixed free-running address-counter/data-output blocks of lab1 with a host write port, start/stop control, a rate divider and a per-sample valid strobe. Its output feeds downstream display/DAC-style consumers that sample on o_valid.

## Interface
- ADDR_WIDTH, 4: table address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 8: table word width.
- DIV_WIDTH, 8: step-divider width.

- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_wr_en  in  1  table write strobe.
- i_wr_addr  in  ADDR_WIDTH  write address.
- i_wr_data  in  DATA_WIDTH  write data.
- i_start  in  1  start/restart playback (level sampled each edge).
- i_stop  in  1  abort playback.
- i_mode  in  2  00 wrap, 01 one-shot, 10 ping-pong, 11 treated as wrap.
- i_last_addr  in  ADDR_WIDTH  final address L of the sequence (first is always 0).
- i_div  in  DIV_WIDTH  D; one step every D+1 cycles.
- o_data  out  DATA_WIDTH  table word of the current sample.
- o_addr  out  ADDR_WIDTH  address the sample came from.
- o_valid  out  1  one-cycle strobe per sample.
- o_busy  out  1  high while not IDLE.
- o_done  out  1  one-cycle pulse on final one-shot sample.

## Operation
- States: IDLE, PLAY. Reset -> IDLE.
- Table: register array, not reset; write on edge when i_wr_en, in any state.
- IDLE: i_start -> PLAY; latch i_mode, i_last_addr, i_div; addr=0, dir=up, divcnt=0.
- PLAY: divcnt increments each edge; when divcnt==D_latched a step occurs: o_data<=mem[addr], o_addr<=addr, o_valid<=1, divcnt<=0, addr advances per mode.
- Wrap: 0,1..L,0,1.. (addr==L -> 0).
- One-shot: 0..L; step at L also sets o_done=1 and returns to IDLE.
- Ping-pong: 0..L,L-1..1,0,1..; endpoints emitted once per turn; dir flips at L and 0. L=0 -> constant 0.
- i_stop in PLAY: next state IDLE, no o_valid/o_done that edge; i_stop has priority over i_start and over a coincident step.
- i_start in PLAY (no i_stop): restart — relatch controls, addr=0, divcnt=0, dir=up; no sample emitted that edge.
- Changes to i_mode/i_last_addr/i_div during PLAY have no effect until next start.
- Address arithmetic is ADDR_WIDTH-bit; L=2^ADDR_WIDTH-1 wraps naturally to 0.
- Write and step to same address on same edge: o_data gets the old word (read-before-write).

## Timing
- Reset values: o_data=0, o_addr=0, o_valid=0, o_busy=0, o_done=0, state IDLE, divcnt=0, dir=up.
- i_rst asserted mid-playback: all above values immediately (asynchronous); table contents kept.
- Start at edge T: o_busy high after T; first step at edge T+D+1, o_valid high in the cycle following it. Subsequent o_valid every D+1 cycles.
- D=0: o_valid high every cycle while playing.
- o_valid, o_done are single-cycle registered pulses; o_data/o_addr hold between samples.
- One-shot: o_busy falls in the same cycle o_done/o_valid for address L are high.
- Stop: o_busy low the cycle after the edge that samples i_stop.

## Test plan
- Reset: write mem[a]=a*16+1 for a=0..15 while i_rst toggles mid-sequence -> all outputs 0 during/after reset, writes after reset retained.
- Wrap, L=3, D=0: o_addr 0,1,2,3,0,1 on consecutive cycles, o_data 0x01,0x11,0x21,0x31,0x01..; first o_valid 2 cycles after start edge cycle.
- One-shot, L=2, D=2: o_valid every 3 cycles at addr 0,1,2; o_done with addr 2; o_busy low thereafter, no further o_valid.
- Ping-pong, L=3, D=0: addr 0,1,2,3,2,1,0,1,2,3; L=0 -> addr 0 repeatedly.
- Stop and restart: i_stop asserted together with a step and i_start -> no o_valid, IDLE; i_start mid-PLAY -> next samples restart at addr 0 after D+1 edges.
- Write hazard: write 0xAA to addr 1 on the edge addr 1 is stepped (old 0x11) -> o_data=0x11; next pass emits 0xAA. L=15 wrap with ADDR_WIDTH=4 -> 15 then 0.
